// File: rtl/bus_port_scheduler_pkg.sv
// ============================================================================
// Module : bus_port_scheduler_pkg
// Brief  : Shared FSM/owner encodings and tag constants for the bus scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_port_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int DEFAULT_TAG_WIDTH = 13;
    localparam int TAG_WRITE_BIT     = DEFAULT_TAG_WIDTH - 1;

endpackage

`default_nettype wire

// File: rtl/sched_port_mux.sv
// ============================================================================
// Module : sched_port_mux
// Brief  : Owner-select routing between the ibus/dbus ports and the system bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sched_port_mux
    import bus_port_scheduler_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  owner_t                    owner,
    input  logic                      req_en,
    input  logic                      resp_en,
    input  logic                      ibus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] ibus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag,
    output logic                      ibus_reqack,
    output logic                      ibus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] ibus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  ibus_resptag,
    input  logic                      ibus_respack,
    input  logic                      dbus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] dbus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag,
    output logic                      dbus_reqack,
    output logic                      dbus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] dbus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  dbus_resptag,
    input  logic                      dbus_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    logic sel_d;
    assign sel_d = (owner == OWN_D);

    always_comb begin
        bus_reqcyc   = 1'b0;
        bus_req      = '0;
        bus_reqtag   = '0;
        ibus_reqack  = 1'b0;
        dbus_reqack  = 1'b0;
        bus_respack  = 1'b0;
        ibus_respcyc = 1'b0;
        ibus_resp    = '0;
        ibus_resptag = '0;
        dbus_respcyc = 1'b0;
        dbus_resp    = '0;
        dbus_resptag = '0;

        if (req_en) begin
            bus_reqcyc  = sel_d ? dbus_reqcyc : ibus_reqcyc;
            bus_req     = sel_d ? dbus_req    : ibus_req;
            bus_reqtag  = sel_d ? dbus_reqtag : ibus_reqtag;
            ibus_reqack = !sel_d && bus_reqack;
            dbus_reqack =  sel_d && bus_reqack;
        end

        // The non-owner sees a silent response channel for the whole read.
        if (resp_en) begin
            bus_respack = sel_d ? dbus_respack : ibus_respack;
            if (sel_d) begin
                dbus_respcyc = bus_respcyc;
                dbus_resp    = bus_resp;
                dbus_resptag = bus_resptag;
            end else begin
                ibus_respcyc = bus_respcyc;
                ibus_resp    = bus_resp;
                ibus_resptag = bus_resptag;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_port_scheduler.sv
// ============================================================================
// Module : bus_port_scheduler
// Brief  : Arbitrates ibus/dbus onto one burst system bus. Define
//          BUS_SCHED_ROUND_ROBIN_EN for round-robin instead of dbus priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_port_scheduler
    import bus_port_scheduler_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BURST_BEATS    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ibus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] ibus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag,
    output logic                      ibus_reqack,
    output logic                      ibus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] ibus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  ibus_resptag,
    input  logic                      ibus_respack,
    input  logic                      dbus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] dbus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag,
    output logic                      dbus_reqack,
    output logic                      dbus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] dbus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  dbus_resptag,
    input  logic                      dbus_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int CNT_W = $clog2(BURST_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);
    // Write bit is the tag MSB; shift the package constant to this tag width.
    localparam int WRITE_BIT = TAG_WRITE_BIT + (BUS_TAG_WIDTH - DEFAULT_TAG_WIDTH);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    owner_t           pick;
    logic             req_beat, resp_beat;

`ifdef BUS_SCHED_ROUND_ROBIN_EN
    owner_t last_q, last_d;

    always_comb begin
        if (ibus_reqcyc && dbus_reqcyc) pick = (last_q == OWN_D) ? OWN_I : OWN_D;
        else                            pick = dbus_reqcyc ? OWN_D : OWN_I;
    end
`else
    assign pick = dbus_reqcyc ? OWN_D : OWN_I;
`endif

    assign req_beat  = bus_reqcyc && bus_reqack;
    assign resp_beat = bus_respcyc && bus_respack;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beat_d  = beat_q;
`ifdef BUS_SCHED_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (ibus_reqcyc || dbus_reqcyc) begin
                    owner_d = pick;
                    state_d = ADDR;
                    beat_d  = '0;
`ifdef BUS_SCHED_ROUND_ROBIN_EN
                    last_d  = pick;
`endif
                end
            end
            ADDR: begin
                if (req_beat) state_d = bus_reqtag[WRITE_BIT] ? WDATA : RDATA;
            end
            WDATA: begin
                if (req_beat) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                    end
                end
            end
            RDATA: begin
                if (resp_beat) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            beat_q  <= '0;
`ifdef BUS_SCHED_ROUND_ROBIN_EN
            last_q  <= OWN_I;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
`ifdef BUS_SCHED_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    sched_port_mux #(
        .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
        .BUS_TAG_WIDTH  (BUS_TAG_WIDTH)
    ) u_mux (
        .owner        (owner_q),
        .req_en       ((state_q == ADDR) || (state_q == WDATA)),
        .resp_en      (state_q == RDATA),
        .ibus_reqcyc  (ibus_reqcyc),
        .ibus_req     (ibus_req),
        .ibus_reqtag  (ibus_reqtag),
        .ibus_reqack  (ibus_reqack),
        .ibus_respcyc (ibus_respcyc),
        .ibus_resp    (ibus_resp),
        .ibus_resptag (ibus_resptag),
        .ibus_respack (ibus_respack),
        .dbus_reqcyc  (dbus_reqcyc),
        .dbus_req     (dbus_req),
        .dbus_reqtag  (dbus_reqtag),
        .dbus_reqack  (dbus_reqack),
        .dbus_respcyc (dbus_respcyc),
        .dbus_resp    (dbus_resp),
        .dbus_resptag (dbus_resptag),
        .dbus_respack (dbus_respack),
        .bus_reqcyc   (bus_reqcyc),
        .bus_req      (bus_req),
        .bus_reqtag   (bus_reqtag),
        .bus_reqack   (bus_reqack),
        .bus_respcyc  (bus_respcyc),
        .bus_resp     (bus_resp),
        .bus_resptag  (bus_resptag),
        .bus_respack  (bus_respack)
    );

endmodule

`default_nettype wire

// File: tb/tb_bus_port_scheduler.sv
// ============================================================================
// Module : tb_bus_port_scheduler
// Brief  : Directed vector table plus corner sequences for bus_port_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_port_scheduler;

    localparam logic [12:0] IT   = 13'h0001;
    localparam logic [12:0] DT   = 13'h1005;
    localparam logic [12:0] DTR  = 13'h0002;
    localparam logic [63:0] IREQ = 64'h0000_0000_0000_1000;
    localparam logic [63:0] DREQ = 64'h0000_0000_2000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ibus_reqcyc, ibus_reqack, ibus_respcyc, ibus_respack;
    logic [63:0] ibus_req, ibus_resp;
    logic [12:0] ibus_reqtag, ibus_resptag;
    logic        dbus_reqcyc, dbus_reqack, dbus_respcyc, dbus_respack;
    logic [63:0] dbus_req, dbus_resp;
    logic [12:0] dbus_reqtag, dbus_resptag;
    logic        bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
    logic [63:0] bus_req, bus_resp;
    logic [12:0] bus_reqtag, bus_resptag;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bus_port_scheduler dut (
        .clk(clk), .reset(reset),
        .ibus_reqcyc(ibus_reqcyc), .ibus_req(ibus_req), .ibus_reqtag(ibus_reqtag),
        .ibus_reqack(ibus_reqack), .ibus_respcyc(ibus_respcyc), .ibus_resp(ibus_resp),
        .ibus_resptag(ibus_resptag), .ibus_respack(ibus_respack),
        .dbus_reqcyc(dbus_reqcyc), .dbus_req(dbus_req), .dbus_reqtag(dbus_reqtag),
        .dbus_reqack(dbus_reqack), .dbus_respcyc(dbus_respcyc), .dbus_resp(dbus_resp),
        .dbus_resptag(dbus_resptag), .dbus_respack(dbus_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respack(bus_respack), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    typedef struct {
        logic        ic, dc;
        logic [12:0] it, dt;
        logic        rack, rcyc, ira, dra;
        logic        e_brc;
        logic [1:0]  e_bsel;   // 0: zero, 1: ibus_req, 2: dbus_req
        logic [12:0] e_btag;
        logic        e_iack, e_dack, e_iresp, e_dresp, e_bra;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ic, input logic [12:0] it, input logic dc,
                       input logic [12:0] dt, input logic rack, input logic rcyc,
                       input logic ira, input logic dra, input logic e_brc,
                       input logic [1:0] e_bsel, input logic [12:0] e_btag,
                       input logic e_iack, input logic e_dack, input logic e_iresp,
                       input logic e_dresp, input logic e_bra);
        vec_t v;
        v.ic = ic; v.it = it; v.dc = dc; v.dt = dt;
        v.rack = rack; v.rcyc = rcyc; v.ira = ira; v.dra = dra;
        v.e_brc = e_brc; v.e_bsel = e_bsel; v.e_btag = e_btag;
        v.e_iack = e_iack; v.e_dack = e_dack;
        v.e_iresp = e_iresp; v.e_dresp = e_dresp; v.e_bra = e_bra;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int ctx, input logic [255:0] got,
                       input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s ctx=%0d got=%h exp=%h", nm, ctx, got, exp);
        end
    endtask

    function automatic logic [255:0] outs_all();
        return 256'({bus_reqcyc, bus_req, bus_reqtag, bus_respack, ibus_reqack,
                     dbus_reqack, ibus_respcyc, ibus_resp, ibus_resptag,
                     dbus_respcyc, dbus_resp, dbus_resptag});
    endfunction

    task automatic drive(input logic ic, input logic [12:0] it, input logic dc,
                         input logic [12:0] dt, input logic rack, input logic rcyc,
                         input logic ira, input logic dra);
        ibus_reqcyc = ic; ibus_reqtag = it; dbus_reqcyc = dc; dbus_reqtag = dt;
        bus_reqack = rack; bus_respcyc = rcyc; ibus_respack = ira; dbus_respack = dra;
    endtask

    // One complete read burst; ed says which port is expected to win.
    task automatic xact_read(input bit wi, input bit wd, input bit ed, input int ctx);
        @(negedge clk); drive(wi, IT, wd, DTR, 1'b0, 1'b0, 1'b1, 1'b1);
        #2 chk("arb_idle", ctx, 256'({bus_reqcyc, ibus_reqack, dbus_reqack}), 256'(0));
        @(negedge clk); bus_reqack = 1'b1;
        #2 chk("grant", ctx, 256'({bus_reqtag, ibus_reqack, dbus_reqack}),
               256'({ed ? DTR : IT, ~ed, ed}));
        for (int b = 0; b < 8; b++) begin
            @(negedge clk); drive(1'b0, IT, 1'b0, DTR, 1'b0, 1'b1, 1'b1, 1'b1);
            bus_resp = 64'hCAFE_0000 + 64'(b);
            #2 chk("rd_beat", ctx * 10 + b, 256'({ibus_respcyc, dbus_respcyc, bus_respack}),
                   256'({~ed, ed, 1'b1}));
        end
        @(negedge clk);
        #2 chk("rd_end", ctx, 256'({ibus_respcyc, dbus_respcyc}), 256'(0));
        @(negedge clk); bus_respcyc = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1; drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_breq;
        bit          ed;

        // Read ibus with stalls on beats 3 and 6; dbus write pending behind it.
        add(1, IT, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        add(0, IT, 0, 0,  1, 0, 0, 0,  0, 1, IT, 1, 0, 0, 0, 0);
        add(1, IT, 1, DT, 1, 0, 0, 0,  1, 1, IT, 1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            logic ra;
            ra = (k != 2) && (k != 6);
            add(0, IT, 1, DT, 1, 1, ra, 1,  0, 0, 0,  0, 0, 1, 0, ra);
        end
        add(0, IT, 1, DT, 1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0);
        // Write dbus: address beat, then eight data beats on every other cycle.
        add(0, IT, 1, DT, 1, 1, 0, 0,  1, 2, DT, 0, 1, 0, 0, 0);
        for (int j = 0; j < 16; j++) begin
            logic ra;
            ra = (j % 2) == 1;
            add(1, IT, 1, DT, ra, 1, 1, 1,  1, 2, DT, 0, ra, 0, 0, 0);
        end
        add(1, IT, 0, 0,  1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0);
        add(1, IT, 0, 0,  0, 0, 0, 0,  1, 1, IT, 0, 0, 0, 0, 0);

        ibus_req = IREQ; dbus_req = DREQ; bus_resp = '0; bus_resptag = '0;
        reset = 1'b1;
        drive(1'b1, IT, 1'b1, DT, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk); #1 chk("reset_outs", 0, outs_all(), 256'(0));
        @(negedge clk); #1 chk("reset_outs", 1, outs_all(), 256'(0));
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].ic, vq[i].it, vq[i].dc, vq[i].dt,
                  vq[i].rack, vq[i].rcyc, vq[i].ira, vq[i].dra);
            bus_resp    = 64'hBEEF_0000 + 64'(i);
            bus_resptag = 13'(i + 3);
            #2;
            exp_breq = (vq[i].e_bsel == 2'd1) ? IREQ : (vq[i].e_bsel == 2'd2) ? DREQ : 64'h0;
            chk("req_side", i, 256'({bus_reqcyc, bus_req, bus_reqtag, ibus_reqack, dbus_reqack}),
                256'({vq[i].e_brc, exp_breq, vq[i].e_btag, vq[i].e_iack, vq[i].e_dack}));
            chk("resp_side", i,
                256'({ibus_respcyc, dbus_respcyc, bus_respack, ibus_resp, dbus_resp,
                      ibus_resptag, dbus_resptag}),
                256'({vq[i].e_iresp, vq[i].e_dresp, vq[i].e_bra,
                      vq[i].e_iresp ? bus_resp : 64'h0, vq[i].e_dresp ? bus_resp : 64'h0,
                      vq[i].e_iresp ? bus_resptag : 13'h0, vq[i].e_dresp ? bus_resptag : 13'h0}));
        end

        // Contention: a lone dbus read first, then four contended reads.
        pulse_reset();
        xact_read(1'b0, 1'b1, 1'b1, 100);
        for (int k = 0; k < 4; k++) begin
`ifdef BUS_SCHED_ROUND_ROBIN_EN
            ed = (k % 2) == 1;
`else
            ed = 1'b1;
`endif
            xact_read(1'b1, 1'b1, ed, 200 + k);
        end

        // Asynchronous reset on response beat 4, then a clean ibus read.
        pulse_reset();
        @(negedge clk); drive(1'b1, IT, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); bus_reqack = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); drive(1'b0, IT, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        @(negedge clk);
        #1 chk("pre_reset_beat4", 300, 256'(ibus_respcyc), 256'(1));
        reset = 1'b1;
        #1 chk("async_reset", 301, outs_all(), 256'(0));
        @(negedge clk); #1 chk("async_reset", 302, outs_all(), 256'(0));
        reset = 1'b0; bus_respcyc = 1'b0;
        xact_read(1'b1, 1'b0, 1'b0, 400);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
